fir_transposed_param: RTL
=========================

Name: fir_transposed_param

Overview:
Parametrised transposed-form FIR filter for the sample-rate datapath. It is the next generation of the fixed 33-tap, 16-bit filter, with these additions:
- generic tap count and widths
- a run-time writable coefficient bank
- sample-valid qualification, so the pipeline stalls on idle cycles
- full-precision accumulation with rounding and overflow detection
- a delay-line flush

It sits between the sample source and downstream decimation or output logic.

Parameters:
DATA_W, 16, input and output sample width, signed two's complement
COEF_W, 16, coefficient width, signed
TAPS, 33, number of taps (filter order + 1), minimum 2
ACC_W, 40, accumulator and partial-sum register width, must be at least DATA_W+COEF_W+clog2(TAPS)
FRAC, 15, right shift applied to the accumulator to form the output, 0 up to ACC_W-DATA_W
ADDR_W, 6, coefficient address width, must be at least clog2(TAPS)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  xin is valid this cycle; the filter advances only when in_valid=1
xin  in  DATA_W  input sample, signed
flush  in  1  clears the delay line; coefficients are kept
coef_we  in  1  coefficient write strobe
coef_addr  in  ADDR_W  tap index, 0 = tap applied to the newest sample
coef_wdata  in  COEF_W  coefficient value, signed
out_valid  out  1  yout is valid; one-cycle pulse per accepted sample
yout  out  DATA_W  filtered sample, signed
ovf  out  1  pulse aligned with out_valid when the output saturated

Behaviour:
Reset:
- rst=1 has priority over everything else.
- Clears yout, out_valid, ovf, all TAPS-1 partial-sum registers and all coefficients to 0.
- With all coefficients at 0, yout stays 0 until coefficients are loaded.

Datapath, on each cycle with in_valid=1:
- Products p[k] = xin * coef[k] are full precision, DATA_W+COEF_W bits, sign-extended to ACC_W.
- Partial sums update as s[k] <= p[k] + s[k+1] for k=1..TAPS-2, and s[TAPS-1] <= p[TAPS-1].
- acc = p[0] + s[1] is combinational.
- Registered next cycle: out_valid=1, yout=sat(round(acc)), ovf=sat_flag.
- Latency is one clock from the in_valid edge to out_valid.
- Throughput is one sample per clock.

Idle cycles, in_valid=0:
- All s[k] and yout hold their values.
- out_valid=0 and ovf=0.
- Gaps in in_valid therefore do not change the output sequence.

Rounding and saturation:
- If FRAC>0, r = (acc + 2^(FRAC-1)) >>> FRAC, an arithmetic shift (round half up). If FRAC=0, r = acc.
- If r > 2^(DATA_W-1)-1, yout = max positive and sat_flag=1.
- If r < -2^(DATA_W-1), yout = min negative and sat_flag=1.
- Otherwise yout = r[DATA_W-1:0] and sat_flag=0.
- Partial sums never saturate. ACC_W sizing guarantees they do not overflow.

Coefficient writes:
- coef_we=1 writes coef[coef_addr] at the clock edge, so the new value is used from the next cycle.
- If coef_we and in_valid are asserted in the same cycle, that sample's products use the old coefficient.
- Writes with coef_addr >= TAPS are ignored and do not change any state.

Flush:
- flush=1 clears all s[k] to 0 at the edge, and also sets out_valid=0 and ovf=0.
- yout holds its value.
- flush has priority over in_valid, and the sample presented that cycle is dropped.
- Coefficient writes still take effect during a flush.

No state machine: the block is a clock-enabled pipeline only.

Optional Feature:
Macro FIR_SYMMETRIC_COEF_EN.
- Defined: only NH = ceil(TAPS/2) coefficient registers are implemented, and coef[k] = coef[TAPS-1-k].
  - A write to address a, with a < NH, updates both mirrored taps.
  - Writes with a >= NH are ignored.
  - Products for mirrored taps are computed once and shared.
- Undefined: TAPS independent coefficient registers, and all addresses below TAPS are writable.

Test Plan:
- Impulse, with TAPS=33, FRAC=0, coef[k]=k+1: x=1, then 40 samples of x=0, all with in_valid=1 -> yout sequence 1,2,...,33, then 0; out_valid high every cycle; ovf=0.
- Positive saturation, with defaults and all coef=0x7FFF: 40 samples of x=0x7FFF -> yout reaches 0x7FFF with ovf=1 once the accumulated sum exceeds range. With x=0x8000 instead -> yout=0x8000 and ovf=1.
- Stall transparency: the impulse test with in_valid toggling 1,0,0,1,... -> the yout values on out_valid cycles match the contiguous run exactly; out_valid=0 on every gap cycle.
- Coefficient write collision: coef[0]=1 is changed to 5 in the same cycle that x=2 is accepted -> that sample contributes 2 from tap 0; the next sample x=2 contributes 10. A write to addr=40 leaves all coefficients unchanged.
- Flush and reset mid-stream: 10 samples in, then flush=1 for one cycle -> the next impulse response starts clean with no residue from the earlier samples. rst=1 asserted mid-stream -> yout=0, out_valid=0, and all coefficients read as 0, so the next output is 0 even for x=0x7FFF.
- Symmetric build, with FIR_SYMMETRIC_COEF_EN defined: write addr 0=3 -> impulse response has 3 at both tap 0 and tap 32. A write to addr 17 is ignored.

Source files
------------

// File: rtl/fir_transposed_param.sv
// Parametrised transposed-form FIR filter with a writable coefficient bank, valid-qualified pipeline and flush.
// Define FIR_SYMMETRIC_COEF_EN to store only ceil(TAPS/2) coefficients and mirror them across the taps.
module fir_transposed_param #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 33,
    parameter int ACC_W  = 40,
    parameter int FRAC   = 15,
    parameter int ADDR_W = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] xin,
    input  logic                     flush,
    input  logic                     coef_we,
    input  logic        [ADDR_W-1:0] coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] yout,
    output logic                     ovf
);

`ifdef FIR_SYMMETRIC_COEF_EN
    localparam int NC = (TAPS + 1) / 2;
`else
    localparam int NC = TAPS;
`endif

    localparam logic signed [ACC_W:0] MAXV = {{(ACC_W + 2 - DATA_W){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] MINV = {{(ACC_W + 2 - DATA_W){1'b1}}, {(DATA_W - 1){1'b0}}};

    logic signed [COEF_W-1:0] coef [NC];
    logic signed [ACC_W-1:0]  prod [NC];
    logic signed [ACC_W-1:0]  p    [TAPS];
    logic signed [ACC_W-1:0]  s    [1:TAPS-1];
    logic signed [ACC_W-1:0]  xin_ext;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W:0]    acc_ext;
    logic signed [ACC_W:0]    r;
    logic signed [DATA_W-1:0] y_next;
    logic                     sat_flag;

    assign xin_ext = ACC_W'(xin);

    // One multiplier per stored coefficient; mirrored taps share the same product.
    always_comb begin
        for (int j = 0; j < NC; j++) begin
            prod[j] = xin_ext * ACC_W'(coef[j]);
        end
    end

    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        localparam int M = (k < NC) ? k : TAPS - 1 - k;
        assign p[k] = prod[M];
    end

    assign acc     = p[0] + s[1];
    assign acc_ext = {acc[ACC_W-1], acc};

    // One extra bit of headroom keeps the rounding offset from wrapping.
    if (FRAC > 0) begin : g_round
        localparam logic [ACC_W:0] HALF = {{ACC_W{1'b0}}, 1'b1} << (FRAC - 1);
        assign r = (acc_ext + $signed(HALF)) >>> FRAC;
    end else begin : g_noround
        assign r = acc_ext;
    end

    always_comb begin
        sat_flag = 1'b0;
        y_next   = r[DATA_W-1:0];
        if (r > MAXV) begin
            sat_flag = 1'b1;
            y_next   = {1'b0, {(DATA_W - 1){1'b1}}};
        end else if (r < MINV) begin
            sat_flag = 1'b1;
            y_next   = {1'b1, {(DATA_W - 1){1'b0}}};
        end
    end

    // Out-of-range addresses match no register and are silently dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < NC; j++) begin
                coef[j] <= '0;
            end
        end else if (coef_we) begin
            for (int j = 0; j < NC; j++) begin
                if (coef_addr == ADDR_W'(j)) begin
                    coef[j] <= coef_wdata;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k < TAPS; k++) begin
                s[k] <= '0;
            end
            yout      <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else if (flush) begin
            for (int k = 1; k < TAPS; k++) begin
                s[k] <= '0;
            end
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else if (in_valid) begin
            for (int k = 1; k < TAPS - 1; k++) begin
                s[k] <= p[k] + s[k+1];
            end
            s[TAPS-1] <= p[TAPS-1];
            yout      <= y_next;
            out_valid <= 1'b1;
            ovf       <= sat_flag;
        end else begin
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end
    end

endmodule
